// File: rtl/uart_mem_loader_if.sv
// rtl/uart_mem_loader_if.sv - memory store/debug bus between the UART loader and the unified memory
//
// Purpose: carries the byte-store request and the debug word index from the
//          loader (master) to the 64-bit unified memory (slave).
// Signals:
//   memwrite   2   store type; 2'b10 selects the byte-store path
//   dataadr    N   byte address of the store
//   writedata  N   store data, byte in bits [7:0]
//   rx_data    8   word index of the most recent store (memory debug index)
interface uart_mem_loader_if #(
    parameter int N = 64
);
    logic [1:0]   memwrite;
    logic [N-1:0] dataadr;
    logic [N-1:0] writedata;
    logic [7:0]   rx_data;

    modport master (
        output memwrite,
        output dataadr,
        output writedata,
        output rx_data
    );

    modport slave (
        input memwrite,
        input dataadr,
        input writedata,
        input rx_data
    );
endinterface

// File: rtl/uart_mem_loader.sv
// rtl/uart_mem_loader.sv - 8N1 UART receiver that stores each byte into memory at consecutive addresses
//
// Purpose: loads a program image over serial by writing every received byte
//          through the memory's byte-store path, walking a byte pointer
//          through a window of MAX_BYTES starting at BASE.
// Ports:
//   clk        in   1   system clock, rising edge
//   reset_n    in   1   asynchronous reset, active-low
//   rx         in   1   UART serial input, idle high, asynchronous to clk
//   enable     in   1   1 = accept frames, 0 = hold IDLE
//   clear      in   1   sync pulse: pointer=BASE, byte_count=0, frame_err=0
//   mem        mst  -   memwrite / dataadr / writedata / rx_data to memory
//   busy       out  1   FSM not in IDLE
//   byte_count out  16  bytes written, wraps at 2^16
//   frame_err  out  1   sticky, stop bit sampled low
module uart_mem_loader #(
    parameter int N            = 64,
    parameter int CLKS_PER_BIT = 868,
    parameter int BASE         = 0,
    parameter int MAX_BYTES    = 1024
) (
    input  logic              clk,
    input  logic              reset_n,
    input  logic              rx,
    input  logic              enable,
    input  logic              clear,
    uart_mem_loader_if.master mem,
    output logic              busy,
    output logic [15:0]       byte_count,
    output logic              frame_err
);

    localparam int CW = (CLKS_PER_BIT > 1) ? $clog2(CLKS_PER_BIT) : 1;
    localparam logic [CW-1:0] CNT_FULL = CW'(CLKS_PER_BIT - 1);
    localparam logic [CW-1:0] CNT_HALF = CW'(CLKS_PER_BIT / 2 - 1);
    localparam logic [N-1:0]  BASE_A   = N'(BASE);
    localparam logic [N-1:0]  LAST_A   = N'(BASE + MAX_BYTES - 1);

    typedef enum logic [2:0] {
        S_IDLE,
        S_START,
        S_DATA,
        S_STOP,
        S_WRITE
    } state_t;

    state_t        state_q, state_d;
    logic          rx_meta, rxs;
    logic [CW-1:0] cnt_q, cnt_d;
    logic [2:0]    bit_q, bit_d;
    logic [7:0]    shift_q, shift_d;
    logic [N-1:0]  ptr_q, ptr_next;
    logic          do_write;
    logic          set_ferr;

    // Two-flop synchroniser, preset to the idle line level so reset never
    // looks like a start bit.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            rx_meta <= 1'b1;
            rxs     <= 1'b1;
        end else begin
            rx_meta <= rx;
            rxs     <= rx_meta;
        end
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_q <= S_IDLE;
            cnt_q   <= '0;
            bit_q   <= '0;
            shift_q <= '0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            bit_q   <= bit_d;
            shift_q <= shift_d;
        end
    end

    always_comb begin
        state_d  = state_q;
        cnt_d    = cnt_q;
        bit_d    = bit_q;
        shift_d  = shift_q;
        do_write = 1'b0;
        set_ferr = 1'b0;
        case (state_q)
            S_IDLE: begin
                if (enable && !rxs) begin
                    state_d = S_START;
                    cnt_d   = '0;
                end
            end
            S_START: begin
                // Re-check the line half a bit in; a high level here was a glitch.
                if (cnt_q == CNT_HALF) begin
                    cnt_d = '0;
                    if (!rxs) begin
                        state_d = S_DATA;
                        bit_d   = '0;
                    end else begin
                        state_d = S_IDLE;
                    end
                end else begin
                    cnt_d = cnt_q + 1'b1;
                end
            end
            S_DATA: begin
                // Counting restarted at the start-bit centre, so each full
                // interval lands in the middle of the next bit.
                if (cnt_q == CNT_FULL) begin
                    cnt_d   = '0;
                    shift_d = {rxs, shift_q[7:1]};
                    if (bit_q == 3'd7) begin
                        state_d = S_STOP;
                    end else begin
                        bit_d = bit_q + 3'd1;
                    end
                end else begin
                    cnt_d = cnt_q + 1'b1;
                end
            end
            S_STOP: begin
                if (cnt_q == CNT_FULL) begin
                    cnt_d = '0;
                    if (rxs) begin
                        state_d = S_WRITE;
                    end else begin
                        set_ferr = 1'b1;
                        state_d  = S_IDLE;
                    end
                end else begin
                    cnt_d = cnt_q + 1'b1;
                end
            end
            S_WRITE: begin
                do_write = 1'b1;
                state_d  = S_IDLE;
            end
            default: state_d = S_IDLE;
        endcase

        // A disabled receiver drops any partial frame, but a store already
        // presented to memory is allowed to finish.
        if (!enable && state_q != S_WRITE) begin
            state_d  = S_IDLE;
            set_ferr = 1'b0;
        end

        if (clear) begin
            state_d  = S_IDLE;
            do_write = 1'b0;
            set_ferr = 1'b0;
        end
    end

    assign ptr_next = (ptr_q == LAST_A) ? BASE_A : ptr_q + 1'b1;

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            ptr_q       <= BASE_A;
            byte_count  <= '0;
            frame_err   <= 1'b0;
            mem.rx_data <= '0;
        end else if (clear) begin
            ptr_q      <= BASE_A;
            byte_count <= '0;
            frame_err  <= 1'b0;
        end else begin
            if (do_write) begin
                ptr_q       <= ptr_next;
                byte_count  <= byte_count + 16'd1;
                mem.rx_data <= ptr_q[10:3];
            end
            if (set_ferr) begin
                frame_err <= 1'b1;
            end
        end
    end

    assign mem.memwrite  = do_write ? 2'b10 : 2'b00;
    assign mem.dataadr   = ptr_q;
    assign mem.writedata = do_write ? {{(N-8){1'b0}}, shift_q} : '0;
    assign busy          = (state_q != S_IDLE);

endmodule

// File: tb/tb_uart_mem_loader.sv
// tb/tb_uart_mem_loader.sv - self-checking bench for uart_mem_loader
module tb_uart_mem_loader;

    localparam int CPB  = 4;
    localparam int MAXB = 16;

    logic        clk     = 1'b0;
    logic        reset_n = 1'b0;
    logic        rx      = 1'b1;
    logic        enable  = 1'b0;
    logic        clear   = 1'b0;
    logic        busy;
    logic        frame_err;
    logic [15:0] byte_count;

    uart_mem_loader_if #(.N(64)) bus ();

    uart_mem_loader #(
        .N(64), .CLKS_PER_BIT(CPB), .BASE(0), .MAX_BYTES(MAXB)
    ) dut (
        .clk(clk), .reset_n(reset_n), .rx(rx), .enable(enable), .clear(clear),
        .mem(bus.master), .busy(busy), .byte_count(byte_count), .frame_err(frame_err)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [63:0] addr;
        logic [7:0]  data;
    } wr_t;

    int          checks   = 0;
    int          failures = 0;
    int          bus_err  = 0;
    wr_t         obs_q[$];
    wr_t         exp_q[$];
    logic [63:0] mem [0:1];

    // reference model state
    int          m_ptr  = 0;
    int          m_cnt  = 0;
    int          m_rxd  = 0;
    logic        m_ferr = 1'b0;
    logic [7:0]  m_bytes [0:MAXB-1];

    // memory model: big-endian byte store, plus bus-protocol watch
    always @(negedge clk) begin
        wr_t w;
        int  lane;
        if (!reset_n) begin
            mem[0] = '0;
            mem[1] = '0;
            if (bus.memwrite !== 2'b00 || bus.writedata !== 64'd0) bus_err++;
        end else if (bus.memwrite === 2'b10) begin
            w.addr = bus.dataadr;
            w.data = bus.writedata[7:0];
            obs_q.push_back(w);
            lane = 63 - 8 * int'(bus.dataadr[2:0]);
            mem[bus.dataadr[3]][lane -: 8] = bus.writedata[7:0];
            if (bus.writedata[63:8] !== 56'd0) bus_err++;
        end else if (bus.memwrite !== 2'b00 || bus.writedata !== 64'd0) begin
            bus_err++;
        end
    end

    task automatic chk(input string tag, input logic [63:0] o, input logic [63:0] e);
        checks++;
        assert (o === e) else begin
            failures++;
            $error("FAIL %s observed=%0h expected=%0h", tag, o, e);
        end
    endtask

    task automatic model_write(input logic [7:0] b);
        wr_t w;
        w.addr = 64'(m_ptr);
        w.data = b;
        exp_q.push_back(w);
        m_bytes[m_ptr] = b;
        m_rxd = m_ptr / 8;
        m_ptr = (m_ptr + 1) % MAXB;
        m_cnt = (m_cnt + 1) % 65536;
    endtask

    function automatic logic [63:0] model_word(input int w);
        logic [63:0] r = '0;
        for (int i = 0; i < 8; i++) r = {r[55:0], m_bytes[8*w + i]};
        return r;
    endfunction

    // frame bits: [0]=start, [8:1]=data LSB first, [9]=stop; entered on a negedge
    task automatic send_bits(input logic [9:0] frame);
        for (int i = 0; i < 10; i++) begin
            rx = frame[i];
            repeat (CPB) @(negedge clk);
        end
        rx = 1'b1;
    endtask

    task automatic send_byte(input logic [7:0] b, input logic stop, input int gap);
        send_bits({stop, b, 1'b0});
        repeat (gap) @(negedge clk);
        if (stop) model_write(b);
        else m_ferr = 1'b1;
    endtask

    task automatic do_clear();
        clear = 1'b1;
        @(negedge clk);
        clear = 1'b0;
        @(negedge clk);
        m_ptr  = 0;
        m_cnt  = 0;
        m_ferr = 1'b0;
    endtask

    task automatic check_writes(input string tag);
        int n;
        chk({tag, "_nwrites"}, 64'(obs_q.size()), 64'(exp_q.size()));
        n = (obs_q.size() < exp_q.size()) ? obs_q.size() : exp_q.size();
        for (int i = 0; i < n; i++) begin
            chk({tag, "_addr"}, obs_q[i].addr, exp_q[i].addr);
            chk({tag, "_data"}, 64'(obs_q[i].data), 64'(exp_q[i].data));
        end
        obs_q.delete();
        exp_q.delete();
    endtask

    task automatic check_state(input string tag);
        chk({tag, "_byte_count"}, 64'(byte_count), 64'(m_cnt));
        chk({tag, "_dataadr"}, bus.dataadr, 64'(m_ptr));
        chk({tag, "_rx_data"}, 64'(bus.rx_data), 64'(m_rxd));
        chk({tag, "_frame_err"}, 64'(frame_err), 64'(m_ferr));
        chk({tag, "_busy"}, 64'(busy), 64'd0);
    endtask

    initial begin
        logic [9:0] fr;
        logic [7:0] b;

        // T1 reset
        repeat (3) @(negedge clk);
        chk("rst_memwrite", 64'(bus.memwrite), 64'd0);
        chk("rst_dataadr", bus.dataadr, 64'd0);
        chk("rst_writedata", bus.writedata, 64'd0);
        chk("rst_rx_data", 64'(bus.rx_data), 64'd0);
        chk("rst_busy", 64'(busy), 64'd0);
        chk("rst_byte_count", 64'(byte_count), 64'd0);
        chk("rst_frame_err", 64'(frame_err), 64'd0);
        reset_n = 1'b1;
        enable  = 1'b1;
        repeat (2) @(negedge clk);
        chk("rel_busy", 64'(busy), 64'd0);
        chk("rel_dataadr", bus.dataadr, 64'd0);

        // T2 single byte
        send_byte(8'hA5, 1'b1, 4);
        check_writes("t2");
        check_state("t2");

        // T3 word fill with a fixed pattern, then the second word with random bytes
        do_clear();
        for (int k = 1; k <= 8; k++) send_byte(8'(8'h11 * k), 1'b1, $urandom_range(3, 9));
        chk("t3_word0_fixed", mem[0], 64'h1122334455667788);
        chk("t3_word0_model", mem[0], model_word(0));
        check_writes("t3a");
        check_state("t3a");
        for (int k = 0; k < 8; k++) send_byte(8'($urandom_range(0, 255)), 1'b1, $urandom_range(3, 9));
        chk("t3_word1_model", mem[1], model_word(1));
        check_writes("t3b");
        check_state("t3b");

        // T4 glitch, then a frame with a low stop bit
        rx = 1'b0;
        @(negedge clk);
        rx = 1'b1;
        repeat (12) @(negedge clk);
        check_writes("t4_glitch");
        chk("t4_glitch_busy", 64'(busy), 64'd0);
        send_byte(8'($urandom_range(0, 255)), 1'b0, 12);
        check_writes("t4_ferr");
        check_state("t4_ferr");

        // T5 wrap over 17 bytes, then clear coinciding with the WRITE cycle
        do_clear();
        check_state("t5_clr");
        for (int k = 0; k < 17; k++) send_byte(8'($urandom_range(0, 255)), 1'b1, $urandom_range(3, 6));
        chk("t5_17th_addr", (obs_q.size() == 17) ? obs_q[16].addr : 64'hDEAD, 64'd0);
        check_writes("t5_wrap");
        check_state("t5_wrap");
        send_bits({1'b1, 8'($urandom_range(0, 255)), 1'b0});
        @(posedge clk);
        #1 clear = 1'b1;
        @(posedge clk);
        #1 clear = 1'b0;
        repeat (4) @(negedge clk);
        m_ptr = 0;
        m_cnt = 0;
        check_writes("t5_clrwr");
        check_state("t5_clrwr");

        // T6 abort by enable mid-DATA
        b  = 8'($urandom_range(0, 255));
        fr = {1'b1, b, 1'b0};
        for (int i = 0; i < 4; i++) begin
            rx = fr[i];
            repeat (CPB) @(negedge clk);
        end
        chk("t6_busy_mid", 64'(busy), 64'd1);
        enable = 1'b0;
        @(negedge clk);
        chk("t6_abort_busy", 64'(busy), 64'd0);
        for (int i = 4; i < 10; i++) begin
            rx = fr[i];
            repeat (CPB) @(negedge clk);
        end
        rx = 1'b1;
        repeat (4) @(negedge clk);
        enable = 1'b1;
        repeat (2) @(negedge clk);
        check_writes("t6_abort");
        check_state("t6_abort");
        send_byte(8'($urandom_range(0, 255)), 1'b1, 5);
        check_writes("t6_recover");
        check_state("t6_recover");

        // T6 async reset mid-frame
        fr = {1'b1, 8'($urandom_range(0, 255)), 1'b0};
        for (int i = 0; i < 5; i++) begin
            rx = fr[i];
            repeat (CPB) @(negedge clk);
        end
        #1 reset_n = 1'b0;
        #1;
        chk("t6_rst_busy", 64'(busy), 64'd0);
        chk("t6_rst_count", 64'(byte_count), 64'd0);
        chk("t6_rst_dataadr", bus.dataadr, 64'd0);
        chk("t6_rst_rx_data", 64'(bus.rx_data), 64'd0);
        rx     = 1'b1;
        m_ptr  = 0;
        m_cnt  = 0;
        m_rxd  = 0;
        m_ferr = 1'b0;
        repeat (3) @(negedge clk);
        reset_n = 1'b1;
        repeat (4) @(negedge clk);
        check_writes("t6_rst");
        check_state("t6_rst");

        chk("bus_protocol", 64'(bus_err), 64'd0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
